// File: rtl/sram_like_arbiter.sv
// Merges the CPU inst and data sram-like ports onto one memory-side sram-like port.
// Optional macro ARB_RR_EN selects round-robin arbitration on ties instead of fixed data priority.
module sram_like_arbiter #(
    parameter int unsigned OUTSTANDING = 2,
    parameter int unsigned CNT_W       = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_req,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,

    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok
);

    localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    logic [OUTSTANDING-1:0] tag_q, tag_d;
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    logic full;
    logic empty;
    logic grant_data;
    logic push;
    logic pop;
    logic head_tag;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(OUTSTANDING - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign full  = (cnt_q == CNT_W'(OUTSTANDING));
    assign empty = (cnt_q == '0);

`ifdef ARB_RR_EN
    logic rr_last_q, rr_last_d;

    // On a tie the source that did not win the last push goes first.
    always_comb begin
        grant_data = data_req;
        if (inst_req && data_req) begin
            grant_data = ~rr_last_q;
        end
    end

    always_comb begin
        rr_last_d = rr_last_q;
        if (push) begin
            rr_last_d = grant_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last_q <= 1'b0;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`else
    always_comb begin
        grant_data = data_req;
    end
`endif

    // Request side: mux the granted source, inst fields when idle.
    always_comb begin
        mem_req      = (inst_req | data_req) & ~full & ~reset;
        mem_wr       = 1'b0;
        mem_size     = inst_size;
        mem_addr     = inst_addr;
        mem_wdata    = '0;
        if (grant_data) begin
            mem_wr    = data_wr;
            mem_size  = data_size;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end
        inst_addr_ok = mem_addr_ok & mem_req & ~grant_data;
        data_addr_ok = mem_addr_ok & mem_req &  grant_data;
    end

    // Response side: the FIFO head tells which source owns this response.
    always_comb begin
        push         = mem_req & mem_addr_ok;
        pop          = mem_data_ok & ~empty & ~reset;
        head_tag     = tag_q[head_q];
        inst_data_ok = pop & ~head_tag;
        data_data_ok = pop &  head_tag;
        inst_rdata   = mem_rdata;
        data_rdata   = mem_rdata;
    end

    always_comb begin
        tag_d  = tag_q;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (push) begin
            tag_d[tail_q] = grant_data;
            tail_d        = ptr_inc(tail_q);
        end
        if (pop) begin
            head_d = ptr_inc(head_q);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            tag_q  <= tag_d;
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench for sram_like_arbiter: directed scenarios then random traffic vs a queue model.
module tb_sram_like_arbiter;

    localparam int unsigned OUT = 2;

    logic        clk;
    logic        reset;
    logic        inst_req;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic        mem_req;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_addr_ok;
    logic        mem_data_ok;

    sram_like_arbiter #(.OUTSTANDING(OUT), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_addr_ok(mem_addr_ok),
        .mem_data_ok(mem_data_ok)
    );

    initial clk = 1'b1;
    always #5 clk = ~clk;

    typedef struct {
        bit          mreq;
        bit          mwr;
        bit [1:0]    msize;
        bit [31:0]   maddr;
        bit [31:0]   mwdata;
        bit          iaok;
        bit          daok;
        bit          idok;
        bit          ddok;
        bit [31:0]   rdata;
    } exp_t;

    exp_t exp_q[$];
    bit   owner_q[$];   // in-order owners of accepted requests: 0=inst, 1=data
    bit   rr_last;
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compare what the DUT presents this cycle against the scoreboard entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mem_req",      32'(mem_req),      32'(e.mreq));
            check("mem_wr",       32'(mem_wr),       32'(e.mwr));
            check("mem_size",     32'(mem_size),     32'(e.msize));
            check("mem_addr",     mem_addr,          e.maddr);
            check("mem_wdata",    mem_wdata,         e.mwdata);
            check("inst_addr_ok", 32'(inst_addr_ok), 32'(e.iaok));
            check("data_addr_ok", 32'(data_addr_ok), 32'(e.daok));
            check("inst_data_ok", 32'(inst_data_ok), 32'(e.idok));
            check("data_data_ok", 32'(data_data_ok), 32'(e.ddok));
            if (e.idok) check("inst_rdata", inst_rdata, e.rdata);
            if (e.ddok) check("data_rdata", data_rdata, e.rdata);
        end
    end

    // Drive one cycle of stimulus, predict outputs from the protocol rules, advance the model.
    task automatic step(input bit r, input bit ir, input logic [31:0] ia,
                        input bit dr, input bit dw, input logic [1:0] ds,
                        input logic [31:0] da, input logic [31:0] dwd,
                        input bit maok, input bit mdok, input logic [31:0] rd);
        exp_t e;
        bit   gd;
        bit   resp;
        reset = r; inst_req = ir; inst_addr = ia; inst_size = 2'b10;
        data_req = dr; data_wr = dw; data_size = ds; data_addr = da; data_wdata = dwd;
        mem_addr_ok = maok; mem_data_ok = mdok; mem_rdata = rd;

        gd = dr;
`ifdef ARB_RR_EN
        if (ir && dr) gd = !rr_last;
`endif
        e.mreq   = (ir || dr) && (owner_q.size() < OUT) && !r;
        e.mwr    = gd ? dw : 1'b0;
        e.msize  = gd ? ds : 2'b10;
        e.maddr  = gd ? da : ia;
        e.mwdata = gd ? dwd : 32'h0;
        e.iaok   = e.mreq && maok && !gd;
        e.daok   = e.mreq && maok && gd;
        resp     = mdok && !r && (owner_q.size() > 0);
        e.idok   = resp && (owner_q[0] == 1'b0);
        e.ddok   = resp && (owner_q[0] == 1'b1);
        e.rdata  = rd;
        exp_q.push_back(e);

        @(posedge clk);
        if (r) begin
            owner_q.delete();
            rr_last = 1'b0;
        end else begin
            if (resp) void'(owner_q.pop_front());
            if (e.mreq && maok) begin
                owner_q.push_back(gd);
                rr_last = gd;
            end
        end
        #1;
    endtask

    task automatic idle(input bit mdok, input logic [31:0] rd);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 2'b10, 32'h0, 32'h0, 1'b0, mdok, rd);
    endtask

    initial begin
        rr_last = 1'b0;
        step(1'b1, 0, 32'h0, 0, 0, 2'b00, 32'h0, 32'h0, 0, 0, 32'h0);
        step(1'b1, 0, 32'h0, 0, 0, 2'b00, 32'h0, 32'h0, 1, 1, 32'h11);

        // Single inst read.
        step(0, 1, 32'hbfc00000, 0, 0, 2'b10, 32'h0, 32'h0, 1, 0, 32'h0);
        idle(0, 32'h0);
        idle(1, 32'h3c080001);
        idle(0, 32'h0);

        // Conflict: both request, data wins, inst follows.
        step(0, 1, 32'hbfc00004, 1, 1, 2'b10, 32'h80000010, 32'hdeadbeef, 1, 0, 32'h0);
        step(0, 1, 32'hbfc00004, 0, 0, 2'b10, 32'h0, 32'h0, 1, 0, 32'h0);
        idle(1, 32'h00000a01);
        idle(1, 32'h00000a02);

        // Full: third request blocked until a response frees a slot.
        step(0, 1, 32'hbfc00008, 0, 0, 2'b10, 32'h0, 32'h0, 1, 0, 32'h0);
        step(0, 0, 32'h0, 1, 0, 2'b01, 32'h80000020, 32'h0, 1, 0, 32'h0);
        step(0, 1, 32'hbfc0000c, 1, 1, 2'b10, 32'h80000024, 32'h1234, 1, 0, 32'h0);
        step(0, 1, 32'hbfc0000c, 0, 0, 2'b10, 32'h0, 32'h0, 1, 1, 32'h00000b01);
        step(0, 1, 32'hbfc0000c, 0, 0, 2'b10, 32'h0, 32'h0, 1, 0, 32'h0);
        idle(1, 32'h00000b02);
        idle(1, 32'h00000b03);

        // Stray response while empty.
        idle(1, 32'hffffffff);
        idle(1, 32'heeeeeeee);

        // Reset with two outstanding; later responses are stray.
        step(0, 1, 32'hbfc00010, 0, 0, 2'b10, 32'h0, 32'h0, 1, 0, 32'h0);
        step(0, 0, 32'h0, 1, 0, 2'b10, 32'h80000030, 32'h0, 1, 0, 32'h0);
        step(1, 1, 32'hbfc00014, 1, 0, 2'b10, 32'h80000034, 32'h0, 1, 1, 32'h00000c01);
        idle(1, 32'h00000c02);
        idle(1, 32'h00000c03);

        // Tie held high with 1-cycle responses.
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 32'hbfc00100 + 32'(i * 4), 1, 0, 2'b10, 32'h80000100 + 32'(i * 4),
                 32'h0, 1, (i > 0), 32'h0000d000 + 32'(i));
        end
        idle(1, 32'h0000d0ff);
        idle(1, 32'h0000d0fe);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 59) == 0,
                 $urandom_range(0, 1) == 1, $urandom,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                 2'($urandom_range(0, 3)), $urandom, $urandom,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom);
        end

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
